// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_ADD    = 3;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction: add 3 (mod 16) when the digit is 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  always_comb begin
    // NOTE: default assignment first so every path drives dout and no latch is inferred.
    dout = din;
    if (din >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
      dout = din + BCD_DIGIT_W'(BCD_ADJ_ADD);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Optional leading-zero blanking output when BIN_TO_BCD_BLANK_EN is defined.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
`ifdef BIN_TO_BCD_BLANK_EN
  output logic [DIGITS-1:0]             blank,
`endif
  output logic                          overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_scr;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_nxt;
  logic             ovf_scr;
  logic             ovf_nxt;
  logic [CNT_W-1:0] cnt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3 u_add3 (
      .din  (bcd_scr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The bit leaving the top digit carries the 10^DIGITS weight, so dropping it
  // leaves bin_in mod 10^DIGITS in the scratch while ovf records the loss.
  assign bcd_nxt = {bcd_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
  assign ovf_nxt = ovf_scr | bcd_adj[BCD_W-1];

`ifdef BIN_TO_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;

  always_comb begin : blank_calc
    logic nz_above;
    blank_nxt = '0;
    nz_above  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz_above     = nz_above | (bcd_nxt[i*BCD_DIGIT_W +: BCD_DIGIT_W] != '0);
      blank_nxt[i] = (i != 0) && !nz_above;
    end
  end
`endif

  // Results are registered on the edge that enters DONE, so they are valid for
  // exactly the cycle in which done is high.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state    <= IDLE;
      bin_sr   <= '0;
      bcd_scr  <= '0;
      ovf_scr  <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
`ifdef BIN_TO_BCD_BLANK_EN
      blank    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin_in;
            bcd_scr <= '0;
            ovf_scr <= 1'b0;
            cnt     <= CNT_W'(WIDTH);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bin_sr  <= {bin_sr[WIDTH-2:0], 1'b0};
          bcd_scr <= bcd_nxt;
          ovf_scr <= ovf_nxt;
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state    <= DONE;
            done     <= 1'b1;
            bcd_out  <= bcd_nxt;
            overflow <= ovf_nxt;
`ifdef BIN_TO_BCD_BLANK_EN
            blank    <= blank_nxt;
`endif
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: 3-digit and 2-digit converters share stimulus and are
// checked against an arithmetic decimal model.
module tb_bin_to_bcd_seq;

  localparam int WIDTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
`ifdef BIN_TO_BCD_BLANK_EN
  logic [2:0]  blank3;
  logic [1:0]  blank2;
`endif

  int ncomp = 0;
  int nfail = 0;

  logic [11:0] prev3;
  logic [7:0]  prev2;
  logic        prev_ovf3, prev_ovf2;

  always #5 clock = ~clock;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(3)) u_dut3 (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy3),
    .done     (done3),
    .bcd_out  (bcd3),
`ifdef BIN_TO_BCD_BLANK_EN
    .blank    (blank3),
`endif
    .overflow (ovf3)
  );

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(2)) u_dut2 (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy2),
    .done     (done2),
    .bcd_out  (bcd2),
`ifdef BIN_TO_BCD_BLANK_EN
    .blank    (blank2),
`endif
    .overflow (ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal digits of v mod 10^digits, ones digit in the low nibble.
  function automatic logic [11:0] bcd_of(input int v, input int digits);
    logic [11:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Digit i is blank when the shown value is below 10^i (never the ones digit).
  function automatic logic [2:0] blank_of(input int v, input int digits);
    logic [2:0] r;
    r = '0;
    for (int i = 1; i < digits; i++) r[i] = (v % pow10(digits)) < pow10(i);
    return r;
  endfunction

  task automatic convert(input logic [7:0] v, input int intr_at = 0, input logic [7:0] intr_v = 8'd0);
    int done_at;
    done_at = 0;
    @(negedge clock);
    start  = 1'b1;
    bin_in = v;
    for (int k = 1; k <= WIDTH + 6; k++) begin
      @(negedge clock);
      if (k == 1) begin
        start  = 1'b0;
        bin_in = 8'($urandom);
      end
      if (done3) begin
        done_at = k;
        break;
      end
      check("hold_bcd3", 32'(bcd3), 32'(prev3));
      check("hold_ovf3", 32'(ovf3), 32'(prev_ovf3));
      check("hold_bcd2", 32'(bcd2), 32'(prev2));
      check("busy_shift", 32'(busy3), 32'd1);
      if (k == intr_at) begin
        start  = 1'b1;
        bin_in = intr_v;
      end else if (k == intr_at + 1) begin
        start = 1'b0;
      end
    end
    check("done_cycle", 32'(done_at), 32'(WIDTH + 1));
    check("bcd3", 32'(bcd3), 32'(bcd_of(int'(v), 3)));
    check("ovf3", 32'(ovf3), 32'(int'(v) >= 1000));
    check("done2", 32'(done2), 32'd1);
    check("bcd2", 32'(bcd2), 32'(bcd_of(int'(v), 2)));
    check("ovf2", 32'(ovf2), 32'(int'(v) >= 100));
`ifdef BIN_TO_BCD_BLANK_EN
    check("blank3", 32'(blank3), 32'(blank_of(int'(v), 3)));
    check("blank2", 32'(blank2), 32'(blank_of(int'(v), 2)));
`endif
    prev3     = bcd_of(int'(v), 3);
    prev2     = 8'(bcd_of(int'(v), 2));
    prev_ovf3 = 1'b0;
    prev_ovf2 = (int'(v) >= 100);
    @(negedge clock);
    check("done_pulse", 32'(done3), 32'd0);
    check("busy_after", 32'(busy3), 32'd0);
    check("done2_pulse", 32'(done2), 32'd0);
  endtask

  initial begin : stim
    int pulses;
    // Reset asserted together with start: reset must win.
    reset  = 1'b1;
    start  = 1'b1;
    bin_in = 8'd255;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy3), 32'd0);
    check("rst_done", 32'(done3), 32'd0);
    check("rst_bcd3", 32'(bcd3), 32'd0);
    check("rst_ovf3", 32'(ovf3), 32'd0);
    check("rst_bcd2", 32'(bcd2), 32'd0);
`ifdef BIN_TO_BCD_BLANK_EN
    check("rst_blank3", 32'(blank3), 32'd0);
`endif
    reset     = 1'b0;
    start     = 1'b0;
    prev3     = '0;
    prev2     = '0;
    prev_ovf3 = 1'b0;
    prev_ovf2 = 1'b0;

    convert(8'd0);
    convert(8'd255);
    convert(8'd99, 3, 8'd200);
    convert(8'd200);

    // Abort a conversion with reset in the 4th SHIFT cycle.
    @(negedge clock);
    start  = 1'b1;
    bin_in = 8'd173;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (k == 4) reset = 1'b1;
    end
    @(negedge clock);
    check("abort_busy", 32'(busy3), 32'd0);
    check("abort_done", 32'(done3), 32'd0);
    check("abort_bcd3", 32'(bcd3), 32'd0);
    check("abort_ovf2", 32'(ovf2), 32'd0);
    reset     = 1'b0;
    prev3     = '0;
    prev2     = '0;
    prev_ovf3 = 1'b0;
    prev_ovf2 = 1'b0;
    pulses    = 0;
    repeat (WIDTH + 4) begin
      @(negedge clock);
      if (done3 || done2) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);

    convert(8'd42);
    convert(8'd150);
    convert(8'd99);
    convert(8'd100);
    convert(8'd7);
    convert(8'd0);
    convert(8'd105);
    convert(8'd199);
    repeat (20) convert(8'($urandom_range(0, 255)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential shift-and-add-3 ("double dabble") converter from unsigned binary to packed BCD.
- Sits upstream of the per-digit 7-segment decoders and produces the 0–9 nibbles they consume. It is the source end of the BCD-nibble interface that feeds HEX0/HEX1/HEX2.
- Uses a start/busy/done handshake and takes one cycle per input bit.
- The result register holds the last completed conversion, so the display never shows partial values.

Parameters:
- WIDTH, 8, bit width of the binary input.
- DIGITS, 3, number of BCD output digits (4 bits each).

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a conversion of BinIn; sampled only in IDLE.
- BinIn  input  WIDTH  unsigned binary value; captured on the accepted Start edge.
- Busy  output  1  high while in SHIFT or DONE.
- Done  output  1  one-cycle pulse when BcdOut/Overflow update.
- BcdOut  output  4*DIGITS  packed BCD; digit 0 (ones) is in bits 3:0.
- Overflow  output  1  high if the last converted BinIn was ≥ 10^DIGITS.

Behaviour:
- Reset: state=IDLE; BcdOut=0; Overflow=0; Busy=0; Done=0; bit counter=0; scratch registers=0. Reset wins over Start in the same cycle. Reset mid-conversion aborts it with no Done pulse.
- FSM states:
  - IDLE: Start=1 → load bin shift reg = BinIn, bcd scratch = 0, ovf scratch = 0, counter = WIDTH; go to SHIFT.
  - SHIFT, each cycle:
    - For every scratch digit ≥ 5, add 3 (mod 16).
    - Shift {bcd scratch, bin reg} left by 1.
    - Bit shifted out of the top digit ORs into ovf scratch.
    - Decrement counter; when the counter reaches 1 in this cycle, go to DONE.
    - Exactly WIDTH SHIFT cycles per conversion.
  - DONE: BcdOut ← bcd scratch; Overflow ← ovf scratch; Done=1 for this cycle only; go to IDLE.
- Latency: Start high at edge N (state IDLE) → SHIFT cycles N+1..N+WIDTH → Done high in cycle N+WIDTH+1, and BcdOut is valid from that same edge. Default latency is 9 cycles.
- Busy=1 in SHIFT and DONE. Start while Busy=1 is ignored, not queued. Back-to-back throughput is one conversion per WIDTH+2 cycles.
- BcdOut and Overflow hold their previous values during SHIFT and change only in DONE.
- Overflow case: BcdOut = BinIn mod 10^DIGITS, i.e. the lost carries are exactly the 10^DIGITS weight. Every digit of BcdOut is always in 0–9, including on overflow.
- BinIn changes after the accepted Start have no effect on the conversion in progress.

Optional Feature:
- Macro: BIN_TO_BCD_BLANK_EN.
- Defined:
  - Adds output port Blank [DIGITS-1:0], registered and updated in the DONE cycle together with BcdOut.
  - Blank[i]=1 iff digit i and all digits above it are 0. Blank[0] is always 0, so a zero value displays as a single "0".
  - Reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package bcd_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - BCD_DIGIT_W=4;
  - BCD_ADJ_THRESH=5;
  - BCD_ADJ_ADD=3.
- Sub-module bcd_add3: combinational 4-bit digit in → corrected digit out (add 3 if ≥5). Instantiated DIGITS times in a generate loop.

Test Plan:
- Reset, then Start with BinIn=0 → Done in cycle 9 after Start, BcdOut=12'h000, Overflow=0, Busy low the cycle after Done.
- BinIn=255 → BcdOut=12'h255, Overflow=0, exactly one Done pulse; BcdOut holds its prior value until Done.
- Start BinIn=99 → 12'h099. On the 3rd SHIFT cycle pulse Start with BinIn=200 → ignored, result 099. A new Start after Busy falls gives 12'h200.
- Start BinIn=173, assert Reset in the 4th SHIFT cycle → no Done, BcdOut=0, state IDLE. Next Start with 42 → 12'h042.
- DIGITS=2, BinIn=150 → BcdOut=8'h50, Overflow=1. Then BinIn=99 → 8'h99, Overflow=0.
- BIN_TO_BCD_BLANK_EN defined:
  - BinIn=7 → Blank=3'b110;
  - BinIn=0 → Blank=3'b110;
  - BinIn=105 → Blank=3'b000.
